// File: rtl/clk_tick_gen.sv
// Lock-supervised clock-enable generator: PLL lock qualification, downstream reset release,
// NUM_CH programmable tick channels. Define CLK_GEN_FRAC_EN for fractional division.

module clk_tick_ch #(
  parameter int DIV_W    = 16,
  parameter int DIV_INIT = 868
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] div_new,
  input  logic [DIV_W-1:0] frac_new,
  output logic             tick
);
  localparam logic [DIV_W:0] ONE = {{DIV_W{1'b0}}, 1'b1};

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W:0]   eff;
  logic [DIV_W:0]   period;
  logic             term;

`ifdef CLK_GEN_FRAC_EN
  logic [DIV_W-1:0] frac_reg;
  logic [DIV_W-1:0] acc;
  logic             carry;
  logic [DIV_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, frac_reg};

  // carry from the previous tick stretches the current period by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_reg <= '0;
      acc      <= '0;
      carry    <= 1'b0;
    end else if (load) begin
      frac_reg <= frac_new;
      acc      <= '0;
      carry    <= 1'b0;
    end else if (!run) begin
      acc      <= '0;
      carry    <= 1'b0;
    end else if (term) begin
      acc      <= sum[DIV_W-1:0];
      carry    <= sum[DIV_W];
    end
  end
`else
  logic frac_unused;
  assign frac_unused = ^frac_new;
`endif

  always_comb begin
    eff = (div_reg == '0) ? ONE : {1'b0, div_reg};
`ifdef CLK_GEN_FRAC_EN
    period = eff + {{DIV_W{1'b0}}, carry};
`else
    period = eff;
`endif
  end

  assign term = ({1'b0, cnt} == (period - ONE));
  // a load in the terminal cycle restarts the channel instead of ticking
  assign tick = run & term & ~load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= DIV_W'(DIV_INIT);
      cnt     <= '0;
    end else if (load) begin
      div_reg <= div_new;
      cnt     <= '0;
    end else if (!run || term) begin
      cnt     <= '0;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end
endmodule

module clk_tick_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int DIV_INIT    = 868,
  parameter int LOCK_STABLE = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_lock,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH*DIV_W-1:0] frac_val,
  input  logic                    clr_lost,
  output logic [NUM_CH-1:0]       tick,
  output logic                    clk_ok,
  output logic                    sys_rst_n,
  output logic                    lock_lost
);
  localparam int SW = (LOCK_STABLE > 2) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);

  typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, RUN} state_t;

  state_t        state;
  logic [SW-1:0] stab;
  logic          lock_m;
  logic          lock_s;
  logic          run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      stab      <= '0;
      lock_lost <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: if (lock_s) begin
          state <= STABILIZE;
          stab  <= '0;
        end
        STABILIZE: begin
          if (!lock_s)                 state <= WAIT_LOCK;
          else if (stab == STAB_LAST)  state <= RUN;
          else                         stab  <= stab + 1'b1;
        end
        RUN:       if (!lock_s) state <= WAIT_LOCK;
        default:   state <= WAIT_LOCK;
      endcase
      // losing lock in RUN outranks a simultaneous clear
      if (state == RUN && !lock_s) lock_lost <= 1'b1;
      else if (clr_lost)           lock_lost <= 1'b0;
    end
  end

  assign run       = (state == RUN);
  assign clk_ok    = run;
  assign sys_rst_n = run;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_tick_ch #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .load     (div_load[i]),
      .div_new  (div_val[i*DIV_W +: DIV_W]),
      .frac_new (frac_val[i*DIV_W +: DIV_W]),
      .tick     (tick[i])
    );
  end
endmodule
